uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 14 +
 rtl/uart_rx_fifo_mem.sv | 37 +++
 rtl/uart_rx_fifo.sv | 102 ++++++++++
 tb/tb_uart_rx_fifo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults and types for the UART receive FIFO.
// Feature macro: UART_RX_FIFO_OVF_CNT_EN (dropped-byte counter).
package uart_rx_fifo_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_THRESH = 8;

  typedef logic [7:0] byte_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// UART RX FIFO storage: DEPTH x 8, sync write port, sync read port.
// Only the read register is reset; the array is not.
module uart_rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  byte_t mem [DEPTH];
  byte_t rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a same-address pop sees the old entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q <= '0;
    end else if (re) begin
      rd_q <= mem[raddr];
    end
  end

  assign rdata = rd_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with level interrupt and sticky overflow.
// Optional UART_RX_FIFO_OVF_CNT_EN adds a saturating drop counter.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int THRESH = DEF_THRESH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  input  logic                    rd_en,
  input  logic                    clr,
  output logic [7:0]              rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    overflow,
`ifdef UART_RX_FIFO_OVF_CNT_EN
  output logic [7:0]              ovf_cnt,
`endif
  output logic                    irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] cnt;
  logic          ovf;
  logic          push;
  logic          pop;
  logic          drop;

  assign empty = (cnt == '0);
  assign full  = (cnt == LW'(DEPTH));

  // A pop frees the slot, so a full FIFO still takes a same-cycle write.
  assign pop  = rd_en & ~empty & ~clr;
  assign push = rx_valid & ~clr & (~full | pop);
  assign drop = rx_valid & ~clr & full & ~rd_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop) begin
        cnt <= cnt + LW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - LW'(1);
      end
      if (drop) ovf <= 1'b1;
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wptr),
    .wdata (rx_byte),
    .re    (pop),
    .raddr (rptr),
    .rdata (rd_data)
  );

`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] ocnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ocnt <= '0;
    end else if (clr) begin
      ocnt <= '0;
    end else if (drop && ocnt != 8'hFF) begin
      ocnt <= ocnt + 8'd1;
    end
  end

  assign ovf_cnt = ocnt;
`endif

  assign level    = cnt;
  assign overflow = ovf;
  assign irq      = (cnt >= LW'(THRESH)) | ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Covers ordering, thresholds, full/empty corners, clr and reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       overflow;
  logic       irq;
`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH  (16),
    .THRESH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rd_en    (rd_en),
    .clr      (clr),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .overflow (overflow),
`ifdef UART_RX_FIFO_OVF_CNT_EN
    .ovf_cnt  (ovf_cnt),
`endif
    .irq      (irq)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_st(input string tag, input int lv, input int ov,
                        input int iq);
    chk({tag, ".level"}, int'(level), lv);
    chk({tag, ".empty"}, int'(empty), int'(lv == 0));
    chk({tag, ".full"}, int'(full), int'(lv == 16));
    chk({tag, ".ovf"}, int'(overflow), ov);
    chk({tag, ".irq"}, int'(irq), iq);
  endtask

  task automatic step(input logic v, input logic [7:0] b,
                      input logic r, input logic c);
    rx_valid = v;
    rx_byte  = b;
    rd_en    = r;
    clr      = c;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_st("reset", 0, 0, 0);
    chk("reset.rd_data", int'(rd_data), 8'h00);
    rst = 1'b1;

    push(8'hA5);
    push(8'h3C);
    chk_st("two", 2, 0, 0);
    pop();
    chk("pop1", int'(rd_data), 8'hA5);
    pop();
    chk("pop2", int'(rd_data), 8'h3C);
    chk_st("drained", 0, 0, 0);
    pop();
    chk("empty_pop", int'(rd_data), 8'h3C);
    chk_st("empty_pop", 0, 0, 0);

    for (int i = 0; i < 7; i++) push(8'h10 + 8'(i));
    chk_st("seven", 7, 0, 0);
    push(8'h17);
    chk_st("eight", 8, 0, 1);
    pop();
    chk("thr_pop", int'(rd_data), 8'h10);
    chk_st("thr_pop", 7, 0, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_st("clr1", 0, 0, 0);

    for (int i = 0; i < 17; i++) push(8'(i));
    chk_st("over", 16, 1, 1);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk($sformatf("ovpop%0d", i), int'(rd_data), i);
    end
    chk_st("ov_drained", 0, 1, 1);
    pop();
    chk("no_10", int'(rd_data), 8'h0F);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_st("clr2", 0, 0, 0);

    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_rw", int'(rd_data), 8'h20);
    chk_st("full_rw", 16, 0, 1);
    for (int i = 1; i < 16; i++) begin
      pop();
      chk($sformatf("frpop%0d", i), int'(rd_data), 8'h20 + i);
    end
    pop();
    chk("last77", int'(rd_data), 8'h77);
    chk_st("fr_drained", 0, 0, 0);

    step(1'b1, 8'h99, 1'b1, 1'b0);
    chk("zero_rw", int'(rd_data), 8'h77);
    chk_st("zero_rw", 1, 0, 0);
    pop();
    chk("pop99", int'(rd_data), 8'h99);

    for (int i = 1; i < 4; i++) push(8'(i));
    step(1'b1, 8'h04, 1'b1, 1'b0);
    chk("mid_rw", int'(rd_data), 8'h01);
    chk_st("mid_rw", 3, 0, 0);
    for (int i = 2; i < 5; i++) begin
      pop();
      chk($sformatf("midpop%0d", i), int'(rd_data), i);
    end

    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    chk_st("clr_rx", 0, 0, 0);
    chk("clr_rd", int'(rd_data), 8'h04);
    pop();
    chk("clr_pop", int'(rd_data), 8'h04);

`ifdef UART_RX_FIFO_OVF_CNT_EN
    for (int i = 0; i < 16; i++) push(8'(i));
    for (int i = 0; i < 300; i++) push(8'hCC);
    chk("ovf_cnt", int'(ovf_cnt), 8'hFF);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cnt_clr", int'(ovf_cnt), 8'h00);
`endif

    push(8'h61);
    push(8'h62);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_st("rst2", 0, 0, 0);
    chk("rst2.rd_data", int'(rd_data), 8'h00);
    rst = 1'b1;
    push(8'h42);
    pop();
    chk("post_rst", int'(rd_data), 8'h42);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
